// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the data-memory responder
// Contents:
//   dmem_resp_state_t : responder FSM state (IDLE/BUSY/RESP)
//   mask_to_bits      : expands a 4-bit byte mask into a 32-bit lane mask
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_resp_state_t;

  function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/dmem_resp_array.sv
// rtl/dmem_resp_array.sv - byte-enabled word array, sync write, comb read
// Ports:
//   clk    : write clock
//   we     : write enable
//   waddr  : write word index
//   wmask  : per-byte write enables
//   wdata  : write data, lanes aligned to wmask
//   raddr  : read word index
//   rdata  : combinational read data
// Contents are intentionally not reset.
module dmem_resp_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wmask,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder, one outstanding request
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   dmem_addr   : byte address (bits [1:0] ignored)
//   dmem_rmask  : read byte enables, nonzero = read request
//   dmem_wmask  : write byte enables, nonzero = write request
//   dmem_wdata  : write data
//   dmem_rdata  : read data, zero unless dmem_resp
//   dmem_resp   : one-cycle completion pulse
//   err         : sticky protocol/range error
module dmem_responder
  import rv32i_types::*;
#(
  parameter int          LATENCY     = 2,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h1ECE_B000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT   = 4'(LATENCY - 1);

  dmem_resp_state_t state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          in_range_q, in_range_d;
  logic [3:0]    rmask_q, rmask_d;
  logic [3:0]    wmask_q, wmask_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          req;
  logic          accept;
  logic [31:0]   offset;
  logic          req_in_range;
  logic          arr_we;
  logic [31:0]   arr_rdata;

  // Unsigned subtraction: addresses below BASE_ADDR wrap to huge offsets
  // and fall out of range naturally.
  assign offset       = dmem_addr - BASE_ADDR;
  assign req_in_range = ({1'b0, offset} < SPAN_BYTES);
  assign req          = |(dmem_rmask | dmem_wmask);
  assign accept       = req && (state_q == IDLE || state_q == RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    in_range_d = in_range_q;
    rmask_d    = rmask_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    err_d      = err_q;

    case (state_q)
      IDLE: state_d = IDLE;
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance in RESP overrides the return to IDLE (back-to-back).
    if (accept) begin
      state_d    = (LATENCY == 1) ? RESP : BUSY;
      cnt_d      = CNT_INIT;
      idx_d      = offset[AW+1:2];
      in_range_d = req_in_range;
      rmask_d    = dmem_rmask;
      wmask_d    = dmem_wmask;
      wdata_d    = dmem_wdata;
      if (!req_in_range || (|dmem_rmask && |dmem_wmask)) err_d = 1'b1;
    end

    // Requests while busy are dropped, not queued.
    if (req && state_q == BUSY) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      in_range_q <= in_range_d;
      rmask_q    <= rmask_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  // Writes commit on the edge that enters RESP, using the transaction that
  // will be in RESP (possibly one accepted this very cycle when LATENCY==1).
  assign arr_we = (state_d == RESP) && in_range_d && (wmask_d != 4'd0);

  dmem_resp_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(idx_d),
    .wmask(wmask_d),
    .wdata(wdata_d),
    .raddr(idx_q),
    .rdata(arr_rdata)
  );

  assign dmem_resp  = (state_q == RESP);
  assign dmem_rdata = (dmem_resp && in_range_q && wmask_q == 4'd0)
                      ? (arr_rdata & mask_to_bits(rmask_q)) : 32'd0;
  assign err        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder at LATENCY 2, 1 and 3
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h1ECE_B000;
  localparam int          NINST = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] t_addr  [NINST];
  logic [3:0]  t_rmask [NINST];
  logic [3:0]  t_wmask [NINST];
  logic [31:0] t_wdata [NINST];
  logic [31:0] t_rdata [NINST];
  logic        t_resp  [NINST];
  logic        t_err   [NINST];

  int cyc = 0;
  int total = 0;
  int passed = 0;

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mem_m [int];
  bit          err_m [NINST];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NINST; g++) begin : g_dut
    dmem_responder #(
      .LATENCY    (g == 0 ? 2 : (g == 1 ? 1 : 3)),
      .DEPTH_WORDS(DEPTH),
      .BASE_ADDR  (BASE)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .dmem_addr (t_addr[g]),
      .dmem_rmask(t_rmask[g]),
      .dmem_wmask(t_wmask[g]),
      .dmem_wdata(t_wdata[g]),
      .dmem_rdata(t_rdata[g]),
      .dmem_resp (t_resp[g]),
      .err       (t_err[g])
    );
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? 8'hFF : 8'h00;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: applies the request's architectural effect immediately
  // and queues the response the pipeline should see LATENCY cycles later.
  task automatic issue(input int inst, input logic [31:0] a, input logic [3:0] rm,
                       input logic [3:0] wm, input logic [31:0] wd,
                       input bit push, input bit commit);
    logic [31:0] off;
    bit          inr;
    int          key;
    logic [31:0] old;
    logic [31:0] exp_rd;
    exp_t        e;
    off    = a - BASE;
    inr    = (longint'(off) / 4) < DEPTH;
    key    = inst * DEPTH + int'(off / 4);
    exp_rd = 32'd0;
    if (commit) begin
      if (!inr || (rm != 0 && wm != 0)) err_m[inst] = 1'b1;
      if (inr && wm != 0) begin
        old = mem_m.exists(key) ? mem_m[key] : 32'd0;
        mem_m[key] = (old & ~lanes(wm)) | (wd & lanes(wm));
      end
      if (inr && wm == 0) exp_rd = mem_m[key] & lanes(rm);
    end
    if (push) begin
      e.inst  = inst;
      e.cyc   = cyc + lat_of(inst);
      e.rdata = exp_rd;
      exp_q.push_back(e);
    end
    t_addr[inst]  = a;
    t_rmask[inst] = rm;
    t_wmask[inst] = wm;
    t_wdata[inst] = wd;
    @(posedge clk);
    #1;
    t_rmask[inst] = 4'd0;
    t_wmask[inst] = 4'd0;
    t_wdata[inst] = 32'd0;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input int inst, input logic [31:0] a, input logic [3:0] rm,
                    input logic [3:0] wm, input logic [31:0] wd);
    issue(inst, a, rm, wm, wd, 1'b1, 1'b1);
    gap(lat_of(inst) - 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic chk_err(input string name);
    for (int g = 0; g < NINST; g++) chk(name, {31'd0, t_err[g]}, {31'd0, err_m[g]});
  endtask

  // Monitor: compares every response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int g = 0; g < NINST; g++) begin
          if (t_resp[g]) begin
            if (exp_q.size() == 0) begin
              total++;
              $display("FAIL unexpected_resp: inst=%0d cycle=%0d rdata=%h", g, cyc, t_rdata[g]);
            end else begin
              e = exp_q.pop_front();
              chk("resp_inst", g, e.inst);
              chk("resp_cycle", cyc, e.cyc);
              chk("resp_rdata", t_rdata[g], e.rdata);
            end
          end else begin
            chk("idle_rdata_zero", t_rdata[g], 32'd0);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NINST; g++) begin
      t_addr[g] = BASE; t_rmask[g] = 4'd0; t_wmask[g] = 4'd0; t_wdata[g] = 32'd0;
      err_m[g] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < NINST; g++) begin
      chk("reset_resp", {31'd0, t_resp[g]}, 32'd0);
      chk("reset_rdata", t_rdata[g], 32'd0);
      chk("reset_err", {31'd0, t_err[g]}, 32'd0);
    end

    // Write then read, LATENCY=2
    op(0, BASE + 8, 4'b0000, 4'b1111, 32'hDEADBEEF);
    drain();
    op(0, BASE + 8, 4'b1111, 4'b0000, 32'd0);
    drain();
    // Byte enables
    op(0, BASE + 16, 4'b0000, 4'b1111, 32'h11223344);
    op(0, BASE + 16, 4'b0000, 4'b0100, 32'hAABBCCDD);
    op(0, BASE + 16, 4'b0110, 4'b0000, 32'd0);
    drain();
    chk_err("err_after_basic");

    // LATENCY=1 back-to-back
    for (int i = 0; i < 4; i++) op(1, BASE + 32'(4 * i), 4'b0000, 4'b1111, 32'hC0DE_0000 + 32'(i));
    for (int i = 0; i < 4; i++) op(1, BASE + 32'(4 * i), 4'b1111, 4'b0000, 32'd0);
    drain();

    // Randomized traffic on each latency
    for (int g = 0; g < NINST; g++) begin
      for (int j = 0; j < 8; j++) op(g, BASE + 32'(4 * j), 4'b0000, 4'b1111, $urandom);
      for (int k = 0; k < 25; k++) begin
        logic [31:0] a;
        a = BASE + 32'(4 * $urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) op(g, a, 4'($urandom_range(1, 15)), 4'b0000, 32'd0);
        else                           op(g, a, 4'b0000, 4'($urandom_range(1, 15)), $urandom);
        gap($urandom_range(0, 1));
      end
      drain();
    end
    chk_err("err_after_random");

    // Out of range, including wrap-around below BASE
    op(0, BASE - 4, 4'b1111, 4'b0000, 32'd0);
    drain();
    op(0, BASE + 32'(4 * DEPTH), 4'b1111, 4'b0000, 32'd0);
    op(0, BASE + 32'(4 * DEPTH), 4'b0000, 4'b1111, 32'h5555AAAA);
    drain();

    // Request while BUSY is ignored, LATENCY=3
    issue(2, BASE + 32'h40, 4'b0000, 4'b1111, 32'h0BAD_F00D, 1'b1, 1'b1);
    issue(2, BASE + 32'h40, 4'b0000, 4'b1111, 32'h1111_2222, 1'b0, 1'b0);
    err_m[2] = 1'b1;
    drain();
    op(2, BASE + 32'h40, 4'b1111, 4'b0000, 32'd0);
    // Simultaneous read and write: write only, rdata zero
    op(2, BASE + 32'h44, 4'b1111, 4'b1111, 32'h7654_3210);
    op(2, BASE + 32'h44, 4'b1111, 4'b0000, 32'd0);
    drain();
    chk_err("err_after_violations");

    // Reset in the middle of a write
    op(2, BASE + 32'h80, 4'b0000, 4'b1111, 32'h1234_5678);
    drain();
    t_addr[2]  = BASE + 32'h80;
    t_wmask[2] = 4'b1111;
    t_wdata[2] = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    t_wmask[2] = 4'd0;
    t_wdata[2] = 32'd0;
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    for (int g = 0; g < NINST; g++) err_m[g] = 1'b0;
    @(negedge clk);
    gap(12);
    chk_err("err_after_reset");
    op(2, BASE + 32'h80, 4'b1111, 4'b0000, 32'd0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder end of the pipeline's data-memory interface. The MEM stage drives addr/rmask/wmask/wdata; this block returns rdata plus a one-cycle resp.
- Backed by a byte-enabled word array with configurable fixed latency and one outstanding request.
- Used as the synthesizable dmem stand-in for pipeline bring-up and as a scoreboard-friendly memory model in the top-level bench.

Parameters:
- LATENCY, 2, cycles from request acceptance to resp; legal range 1..15.
- DEPTH_WORDS, 1024, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h1ECE_B000, byte address of word 0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- dmem_addr  in  32  byte address; bits [1:0] ignored, because the pipeline aligns addresses and shifts the masks.
- dmem_rmask  in  4  read byte enables; nonzero = read request this cycle.
- dmem_wmask  in  4  write byte enables; nonzero = write request this cycle.
- dmem_wdata  in  32  write data, byte lanes aligned to wmask.
- dmem_rdata  out  32  read data, valid only while dmem_resp=1.
- dmem_resp  out  1  one-cycle completion pulse for reads and writes.
- err  out  1  sticky protocol/range error flag; cleared only by rst.

Behaviour:
- Reset (async assert, sync release): state=IDLE, counter=0, dmem_resp=0, dmem_rdata=0, err=0, captured request cleared. Array contents are not reset (undefined until written).
- Request detection: a request is present when (rmask|wmask)!=0. It is sampled only when state=IDLE, or when state=RESP (back-to-back accept in the cycle resp is high).
- FSM states, enum dmem_resp_state_t:
  - IDLE: on request, capture addr/rmask/wmask/wdata and set counter=LATENCY-1. Go to RESP if LATENCY==1, else BUSY.
  - BUSY: decrement counter each cycle; when counter==1, go to RESP.
  - RESP: dmem_resp=1 for exactly this cycle. Go to IDLE, or straight to BUSY/RESP if a new request is accepted this cycle.
- Latency: request sampled at edge t → dmem_resp high during cycle t+LATENCY. Sustained throughput is one transaction per LATENCY cycles.
- Write commit: bytes with wmask[i]=1 are written on the RESP-entry edge, not at acceptance. Reset before resp therefore drops the write entirely.
- Read data:
  - Word read from the array at resp time.
  - Byte lanes with rmask[i]=0 are forced to 0.
  - dmem_rdata=0 whenever dmem_resp=0 and for write-only transactions.
- Both rmask and wmask nonzero in one request: set err. Perform the write only, and return rdata=0.
- Request while BUSY: ignored (not queued) and err set. The in-flight transaction completes unaffected.
- Range: word index = (addr-BASE_ADDR)>>2. If the address is below BASE_ADDR or the index ≥ DEPTH_WORDS:
  - err is set.
  - Writes are suppressed and rdata=0.
  - resp still fires at nominal latency, so the pipeline never hangs.
- Wrap-around: the address subtraction is 32-bit unsigned. An underflow yields a large index and is treated as out of range.
- Reset mid-operation: the pending transaction is discarded and no resp is issued after reset release.

Decomposition:
- Add dmem_resp_state_t (IDLE/BUSY/RESP, logic [1:0]) to package rv32i_types.
- Sub-module dmem_resp_array: byte-enabled DEPTH_WORDS×32 array with synchronous write and combinational read.
- The responder FSM, counter, range check and mask gating stay in dmem_responder.

Test Plan:
- Write then read, LATENCY=2: write addr=BASE_ADDR+8, wmask=4'b1111, wdata=32'hDEADBEEF → resp 2 cycles later. Then read addr=BASE_ADDR+8, rmask=4'b1111 → resp 2 cycles later with rdata=32'hDEADBEEF, err=0.
- Byte enables: write 32'h11223344 mask 1111, then write 32'hAABBCCDD mask 0100, then read with rmask 4'b0110 → rdata=32'h00BB3300.
- LATENCY=1 back-to-back: requests on consecutive resp cycles → resp high every cycle for 4 transactions, no dropped writes, and readback matches.
- Out of range: read addr=BASE_ADDR-4 and addr=BASE_ADDR+4*DEPTH_WORDS → each gets resp at nominal latency with rdata=0, and err=1 stays set.
- Protocol violation: second request one cycle after the first with LATENCY=3 → single resp at t+3 for the first request only, err=1. Request with rmask and wmask both nonzero → write performed, rdata=0, err=1.
- Reset mid-op: write accepted, rst pulsed asynchronously before resp → no resp ever issued, err=0. A later read of that address does not return the dropped wdata.
